// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared encodings and helpers for the ALU arbiter/sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EXEC = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;

    localparam logic [6:0] OP_0 = 7'b1000000;
    localparam logic [6:0] OP_1 = 7'b0100000;
    localparam logic [6:0] OP_2 = 7'b0010000;
    localparam logic [6:0] OP_3 = 7'b0001000;
    localparam logic [6:0] OP_4 = 7'b0000100;
    localparam logic [6:0] OP_5 = 7'b0000010;
    localparam logic [6:0] OP_6 = 7'b0000001;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant; contention goes to the requester
//               that was not granted last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_id,
    output logic grant_valid
);

    assign grant_valid = valid0 | valid1;
    assign grant_id    = (valid0 && valid1) ? ~last_grant : valid1;

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between two requesters and sequences its
//               load/execute phases, returning results on one response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int OPS     = 7,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPS-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPS-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             alu_on,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [OPS-1:0]   alu_out_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic [1:0]       state
);
    import alu_ctrl_pkg::*;

    localparam int                 c_cnt_w    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(ALU_LAT - 1);

    state_t             r_state;
    logic               r_init;
    logic               r_last_grant;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_alu_on;
    logic [2:0]         r_in_sel;
    logic [WIDTH-1:0]   r_num1;
    logic [WIDTH-1:0]   r_num2;
    logic [OPS-1:0]     r_out_sel;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_err;

    logic               w_gnt_id;
    logic               w_gnt_vld;
    logic               w_accept_ok;
    logic               w_hs;
    logic [OPS-1:0]     w_op;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    rr_arbiter2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (r_last_grant),
        .grant_id    (w_gnt_id),
        .grant_valid (w_gnt_vld)
    );

    assign w_accept_ok = (r_state == ST_IDLE) && !r_init && !rst;
    assign req0_ready  = w_accept_ok && w_gnt_vld && !w_gnt_id;
    assign req1_ready  = w_accept_ok && w_gnt_vld && w_gnt_id;
    assign w_hs        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_op        = w_gnt_id ? req1_op : req0_op;
    assign w_a         = w_gnt_id ? req1_a  : req0_a;
    assign w_b         = w_gnt_id ? req1_b  : req0_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_init       <= 1'b1;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_alu_on     <= 1'b0;
            r_in_sel     <= IN_SEL_RESET;
            r_num1       <= '0;
            r_num2       <= '0;
            r_out_sel    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else if (r_init) begin
            // First edge powers the ALU while still holding it in reset;
            // the second edge releases it to persist and opens arbitration.
            r_alu_on <= 1'b1;
            r_init   <= !r_alu_on;
            r_in_sel <= r_alu_on ? IN_SEL_PERSIST : IN_SEL_RESET;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_sel <= IN_SEL_PERSIST;
                    if (w_hs) begin
                        r_last_grant <= w_gnt_id;
                        r_rsp_id     <= w_gnt_id;
                        if (is_onehot(32'(w_op))) begin
                            r_state   <= ST_LOAD;
                            r_in_sel  <= IN_SEL_LOAD;
                            r_num1    <= w_a;
                            r_num2    <= w_b;
                            r_out_sel <= w_op;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    r_state  <= ST_EXEC;
                    r_in_sel <= IN_SEL_PERSIST;
                    r_cnt    <= c_cnt_load;
                end
                ST_EXEC: begin
                    r_in_sel <= IN_SEL_PERSIST;
                    if (r_cnt == '0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= alu_out;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                ST_RESP: begin
                    r_in_sel <= IN_SEL_PERSIST;
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign alu_on      = r_alu_on;
    assign alu_in_sel  = r_in_sel;
    assign alu_num1    = r_num1;
    assign alu_num2    = r_num2;
    assign alu_out_sel = r_out_sel;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0] rsp_data;
    logic       alu_on;
    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1, alu_num2, alu_out;
    logic [6:0] alu_out_sel;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8), .OPS(7), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1),
        .alu_num2(alu_num2), .alu_out_sel(alu_out_sel), .alu_out(alu_out),
        .state(state)
    );

    // ALU model: latches operands and op while in_sel selects load.
    logic [7:0] m_a, m_b;
    logic [6:0] m_op;
    always @(posedge clk) begin
        if (alu_in_sel == 3'b010) begin
            m_a  <= alu_num1;
            m_b  <= alu_num2;
            m_op <= alu_out_sel;
        end
    end
    always_comb begin
        case (m_op)
            7'b1000000: alu_out = m_a + m_b;
            7'b0100000: alu_out = m_a - m_b;
            7'b0000100: alu_out = m_a ^ m_b;
            default:    alu_out = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 7'b1000000; req0_a = 8'h57; req0_b = 8'h1A;
        req1_valid = 1'b0; req1_op = 7'b0000011; req1_a = 8'h00; req1_b = 8'h00;

        // Reset held for two edges
        repeat (2) @(negedge clk);
        chk("rst_state",   32'(state), 32'(2'b00));
        chk("rst_alu_on",  32'(alu_on), 32'd0);
        chk("rst_in_sel",  32'(alu_in_sel), 32'(3'b001));
        chk("rst_out_sel", 32'(alu_out_sel), 32'd0);
        chk("rst_num1",    32'(alu_num1), 32'd0);
        chk("rst_num2",    32'(alu_num2), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id), 32'd0);
        chk("rst_ready0",    32'(req0_ready), 32'd0);
        rst = 1'b0;

        @(negedge clk);
        chk("init_alu_on", 32'(alu_on), 32'd1);
        chk("init_in_sel", 32'(alu_in_sel), 32'(3'b001));
        chk("init_ready0", 32'(req0_ready), 32'd0);
        chk("init_state",  32'(state), 32'(2'b00));

        // Single request from req0: add 57 + 1A
        @(negedge clk);
        chk("idle_in_sel", 32'(alu_in_sel), 32'(3'b100));
        chk("idle_ready0", 32'(req0_ready), 32'd1);
        chk("idle_ready1", 32'(req1_ready), 32'd0);

        @(negedge clk);
        req0_valid = 1'b0;
        chk("load_state",   32'(state), 32'(2'b01));
        chk("load_in_sel",  32'(alu_in_sel), 32'(3'b010));
        chk("load_num1",    32'(alu_num1), 32'h57);
        chk("load_num2",    32'(alu_num2), 32'h1A);
        chk("load_out_sel", 32'(alu_out_sel), 32'(OP_0));

        @(negedge clk);
        chk("exec_state",   32'(state), 32'(2'b10));
        chk("exec_in_sel",  32'(alu_in_sel), 32'(3'b100));
        chk("exec_out_sel", 32'(alu_out_sel), 32'(OP_0));
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);

        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data",  32'(rsp_data), 32'h71);
        chk("rsp_id",    32'(rsp_id), 32'd0);
        chk("rsp_err",   32'(rsp_err), 32'd0);

        // Back-pressure with an illegal req1 command waiting
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_state",   32'(state), 32'(2'b11));
            chk("bp_valid",   32'(rsp_valid), 32'd1);
            chk("bp_data",    32'(rsp_data), 32'h71);
            chk("bp_id",      32'(rsp_id), 32'd0);
            chk("bp_ready0",  32'(req0_ready), 32'd0);
            chk("bp_ready1",  32'(req1_ready), 32'd0);
            chk("bp_in_sel",  32'(alu_in_sel), 32'(3'b100));
            chk("bp_out_sel", 32'(alu_out_sel), 32'(OP_0));
        end
        rsp_ready = 1'b1;

        @(negedge clk);
        chk("rel_state",  32'(state), 32'(2'b00));
        chk("rel_valid",  32'(rsp_valid), 32'd0);
        chk("rel_ready1", 32'(req1_ready), 32'd1);
        chk("rel_ready0", 32'(req0_ready), 32'd0);

        // Illegal op answered the next cycle without LOAD/EXEC
        @(negedge clk);
        req1_valid = 1'b0;
        chk("ill_state",   32'(state), 32'(2'b11));
        chk("ill_valid",   32'(rsp_valid), 32'd1);
        chk("ill_err",     32'(rsp_err), 32'd1);
        chk("ill_data",    32'(rsp_data), 32'd0);
        chk("ill_id",      32'(rsp_id), 32'd1);
        chk("ill_in_sel",  32'(alu_in_sel), 32'(3'b100));
        chk("ill_out_sel", 32'(alu_out_sel), 32'(OP_0));

        @(negedge clk);
        chk("ill_done_state", 32'(state), 32'(2'b00));
        chk("ill_done_valid", 32'(rsp_valid), 32'd0);

        // Reset during EXEC: 50 - 13 in flight is dropped
        req0_valid = 1'b1; req0_op = OP_1; req0_a = 8'h50; req0_b = 8'h13;
        @(negedge clk);
        chk("mid_load_state", 32'(state), 32'(2'b01));
        @(negedge clk);
        chk("mid_exec_state", 32'(state), 32'(2'b10));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_state",   32'(state), 32'(2'b00));
        chk("mid_rst_valid",   32'(rsp_valid), 32'd0);
        chk("mid_rst_in_sel",  32'(alu_in_sel), 32'(3'b001));
        chk("mid_rst_alu_on",  32'(alu_on), 32'd0);
        chk("mid_rst_out_sel", 32'(alu_out_sel), 32'd0);
        chk("mid_rst_num1",    32'(alu_num1), 32'd0);
        @(negedge clk);
        chk("mid_init_alu_on", 32'(alu_on), 32'd1);
        chk("mid_init_in_sel", 32'(alu_in_sel), 32'(3'b001));
        chk("mid_init_ready0", 32'(req0_ready), 32'd0);
        chk("mid_init_valid",  32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("mid_idle_in_sel", 32'(alu_in_sel), 32'(3'b100));

        // Continuous contention: req0 (50-13=3D) and req1 (F0^3C=CC) alternate
        req1_valid = 1'b1; req1_op = OP_4; req1_a = 8'hF0; req1_b = 8'h3C;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("cont_ready0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_ready1", 32'(req1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            repeat (3) @(negedge clk);
            chk("cont_state", 32'(state), 32'(2'b11));
            chk("cont_valid", 32'(rsp_valid), 32'd1);
            chk("cont_id",    32'(rsp_id), (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("cont_data",  32'(rsp_data), (k % 2 == 0) ? 32'h3D : 32'hCC);
            chk("cont_err",   32'(rsp_err), 32'd0);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
            #1;
            chk("cont_idle", 32'(state), 32'(2'b00));
        end

        repeat (2) @(negedge clk);
        chk("end_state", 32'(state), 32'(2'b00));
        chk("end_valid", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
